// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receive path.
//   DATA_BITS  : payload bits per 8N1 frame
//   rx_state_e : receiver FSM states
//   baud_div() : bit period in clock cycles, rounded to nearest
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core -- 8N1 deserialiser: 2-flop synchroniser, receiver FSM and
// bit-period counter.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_rx           : raw serial line, asynchronous, idles high
//   o_byte         : last assembled byte (valid while o_done is high)
//   o_done         : 1-cycle pulse in the cycle the stop bit samples high
//   o_frame_err    : registered 1-cycle pulse after a stop bit samples low
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV = 104
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_byte,
  output logic                 o_done,
  output logic                 o_frame_err
);

  localparam int CNT_W = $clog2(DIV) + 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);

  logic                 r_sync1, r_sync2, r_sync_prev;
  rx_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]     r_bit_idx, w_bit_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_frame_err, w_frame_err_nxt;
  logic                 w_tc, w_fall;

  // r_sync_prev holds the previous synchronised level so a start is a true
  // 1->0 transition; all three reset high so a low line at release is not a start.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values and the order of statements does not matter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_sync_prev <= 1'b1;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= i_rx;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  assign w_tc   = (r_cnt == '0);
  assign w_fall = r_sync_prev & ~r_sync2;

  // NOTE: every signal gets a default before the case statement, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = w_tc ? r_cnt : r_cnt - 1'b1;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_frame_err_nxt = 1'b0;
    o_done          = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_cnt_nxt   = HALF_LOAD;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_tc) begin
          if (!r_sync2) begin
            w_cnt_nxt     = FULL_LOAD;
            w_bit_idx_nxt = '0;
            w_state_nxt   = DATA;
          end else begin
            w_state_nxt = IDLE;  // glitch shorter than half a bit
          end
        end
      end
      DATA: begin
        if (w_tc) begin
          w_shift_nxt = {r_sync2, r_shift[DATA_BITS-1:1]};  // LSB arrives first
          w_cnt_nxt   = FULL_LOAD;
          if (r_bit_idx == LAST_BIT) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_tc) begin
          if (r_sync2) begin
            o_done      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = BREAK;
          end
        end
      end
      BREAK: begin
        if (r_sync2) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_byte      = r_shift;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- UART receiver with a show-ahead byte FIFO and RTS flow
// control, feeding the character interpreter over valid/ready.
// Optional feature macro: UART_RX_RTS_EN (drives o_rts_n from the free count;
// when undefined o_rts_n is tied low).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_rx           : serial line from host, idles high
//   o_char         : head-of-FIFO byte, 8'h00 when empty
//   o_valid        : FIFO not empty
//   i_ready        : consumer takes o_char this cycle
//   o_frame_err    : 1-cycle pulse, stop bit sampled low
//   o_overrun      : 1-cycle pulse, good byte dropped on a full FIFO
//   o_rts_n        : active-low request-to-send
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int DEPTH      = 16,
  parameter int RTS_MARGIN = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_char,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_rts_n
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;

  logic [DATA_BITS-1:0] w_rx_byte;
  logic                 w_rx_done;

  uart_rx_core #(
    .DIV (DIV)
  ) u_core (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rx        (i_rx),
    .o_byte      (w_rx_byte),
    .o_done      (w_rx_done),
    .o_frame_err (o_frame_err)
  );

  logic [PW-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic          w_empty, w_full, w_pop, w_push, w_drop;
  logic          r_overrun;

  // Extra MSB on each pointer distinguishes full from empty.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop   = ~w_empty & i_ready;
  // A push onto a full FIFO is fine when the head leaves on the same edge:
  // the write lands in the slot being vacated.
  assign w_push  = w_rx_done & (~w_full | w_pop);
  assign w_drop  = w_rx_done & w_full & ~w_pop;

  assign w_wr_ptr_nxt = w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
  assign w_rd_ptr_nxt = w_pop  ? r_rd_ptr + 1'b1 : r_rd_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_overrun <= w_drop;
    end
  end

  // NOTE: the storage array has no reset; pointers define which entries are
  // live and o_char is gated while empty, so stale contents are never seen.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_rx_byte;
  end

  assign o_valid   = ~w_empty;
  assign o_char    = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_overrun = r_overrun;

`ifdef UART_RX_RTS_EN
  logic [PW-1:0] w_count_nxt, w_free_nxt;
  logic          r_rts_n;

  // Registered from the post-update occupancy, level based.
  assign w_count_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
  assign w_free_nxt  = PW'(DEPTH) - w_count_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rts_n <= 1'b0;
    else          r_rts_n <= (int'(w_free_nxt) <= RTS_MARGIN);
  end

  assign o_rts_n = r_rts_n;
`else
  assign o_rts_n = 1'b0;
`endif

endmodule
